// File: rtl/decoder_scan_pkg.sv
// Shared constants and state encoding for the decoder scan controller.
// Channel count, select width and FSM state type used by all scan files.
package decoder_scan_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;
endpackage

// File: rtl/decoder_scan_next_ch.sv
// Combinational circular priority picker: next enabled channel after cur,
// or the lowest enabled channel when starting from idle; wrap flags index roll-over.
module decoder_scan_next_ch
   import decoder_scan_pkg::*;
(
   input  logic [SEL_W-1:0]  cur,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              from_idle,
   output logic [SEL_W-1:0]  nxt,
   output logic              wrap
);

   logic [SEL_W-1:0] start_s;
   logic             found_s;

   // Circular first-hit search starting just after cur (or at channel 0)
   always_comb begin
      logic [SEL_W-1:0] cand_v;
      logic             hit_v;
      start_s = from_idle ? {SEL_W{1'b0}} : (cur + SEL_W'(1));
      nxt     = cur;
      found_s = 1'b0;
      cand_v  = {SEL_W{1'b0}};
      hit_v   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand_v  = start_s + SEL_W'(i);
         hit_v   = ch_mask[cand_v] & ~found_s;
         nxt     = hit_v ? cand_v : nxt;
         found_s = found_s | hit_v;
      end
      wrap = ~from_idle & found_s & (nxt <= cur);
   end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan sequencer driving A1/A0/E of a 2-to-4 decoder with blank and dwell phases.
// Optional macro DECODER_SCAN_HOLD_EN adds a hold input that freezes the sequencer.
module decoder_scan_ctrl
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 8,
   parameter int BLANK_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [NUM_CH-1:0] ch_mask,
`ifdef DECODER_SCAN_HOLD_EN
   input  logic              hold,
`endif
   output logic              a1,
   output logic              a0,
   output logic              e,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   // With no blank phase a new channel is entered directly in DRIVE
   localparam scan_state_t      ENTRY_ST   = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   scan_state_t      state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [SEL_W-1:0] sel_r, sel_nxt_s;
   logic             e_r, busy_r, frame_done_r, frame_done_nxt_s;
   logic [SEL_W-1:0] pick_sel_s;
   logic             pick_wrap_s;
   logic             hold_s;

`ifdef DECODER_SCAN_HOLD_EN
   assign hold_s = hold;
`else
   assign hold_s = 1'b0;
`endif

   decoder_scan_next_ch u_next_ch (
      .cur       (sel_r),
      .ch_mask   (ch_mask),
      .from_idle (state_r == IDLE),
      .nxt       (pick_sel_s),
      .wrap      (pick_wrap_s)
   );

   // Next-state, phase counter, select and frame pulse computation
   always_comb begin
      state_nxt_s      = state_r;
      cnt_nxt_s        = cnt_r;
      sel_nxt_s        = sel_r;
      frame_done_nxt_s = 1'b0;
      if (hold_s) begin
         frame_done_nxt_s = frame_done_r;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_nxt_s = {CNT_W{1'b0}};
               if (run && (ch_mask != {NUM_CH{1'b0}})) begin
                  sel_nxt_s   = pick_sel_s;
                  state_nxt_s = ENTRY_ST;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_nxt_s = DRIVE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s   = cnt_r + CNT_W'(1);
               end
            end
            DRIVE: begin
               if (cnt_r == DWELL_LAST) begin
                  cnt_nxt_s = {CNT_W{1'b0}};
                  // Run and mask only matter at the channel boundary
                  if (!run || (ch_mask == {NUM_CH{1'b0}})) begin
                     state_nxt_s = IDLE;
                  end else begin
                     sel_nxt_s        = pick_sel_s;
                     state_nxt_s      = ENTRY_ST;
                     frame_done_nxt_s = pick_wrap_s;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // State and output registers; e and busy follow the next state so they align with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         sel_r        <= {SEL_W{1'b0}};
         e_r          <= 1'b1;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         sel_r        <= sel_nxt_s;
         e_r          <= (state_nxt_s != DRIVE);
         busy_r       <= (state_nxt_s != IDLE);
         frame_done_r <= frame_done_nxt_s;
      end
   end

   assign a1         = sel_r[1];
   assign a0         = sel_r[0];
   assign e          = e_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed self-checking bench for decoder_scan_ctrl (DWELL=4, BLANK=1).
// Hold scenario compiled only when DECODER_SCAN_HOLD_EN is defined.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [3:0] ch_mask;
`ifdef DECODER_SCAN_HOLD_EN
   logic       hold;
`endif
   logic       a1, a0, e, busy, frame_done;
   logic [3:0] y;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decoder_scan_ctrl #(
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (1),
      .CNT_W        (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .ch_mask    (ch_mask),
`ifdef DECODER_SCAN_HOLD_EN
      .hold       (hold),
`endif
      .a1         (a1),
      .a0         (a0),
      .e          (e),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Behavioural stand-in for the downstream 2-to-4 decoder (active-high Y)
   assign y = e ? 4'b0000 : (4'b0001 << {a1, a0});

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [3:0] m, input logic r);
      rst_n   = 1'b0;
      run     = r;
      ch_mask = m;
`ifdef DECODER_SCAN_HOLD_EN
      hold    = 1'b0;
`endif
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      run     = 1'b1;
      ch_mask = 4'hF;
`ifdef DECODER_SCAN_HOLD_EN
      hold    = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({e, a1, a0, busy, frame_done} !== 5'b10000)
            begin n_fail++; $display("FAIL reset cyc%0d: got e,a1,a0,busy,fd=%b want 10000", k, {e, a1, a0, busy, frame_done}); end
      end
   endtask

   task automatic test_full_scan;
      int slot, ph;
      logic [1:0] ch;
      logic exp_fd;
      apply_reset(4'hF, 1'b1);
      for (int k = 1; k <= 45; k++) begin
         tick();
         slot   = (k - 1) / 5;
         ph     = (k - 1) % 5;
         ch     = 2'(slot % 4);
         exp_fd = (ph == 0) && (slot > 0) && (slot % 4 == 0);
         n_checks++;
         if ({e, a1, a0, busy} !== {(ph == 0), ch, 1'b1})
            begin n_fail++; $display("FAIL full_scan k=%0d: got e,sel,busy=%b want %b", k, {e, a1, a0, busy}, {(ph == 0), ch, 1'b1}); end
         n_checks++;
         if (frame_done !== exp_fd)
            begin n_fail++; $display("FAIL full_scan_fd k=%0d: got %b want %b", k, frame_done, exp_fd); end
         n_checks++;
         if (y !== ((ph == 0) ? 4'b0000 : (4'b0001 << ch)))
            begin n_fail++; $display("FAIL full_scan_y k=%0d: got %b", k, y); end
      end
   endtask

   task automatic test_sparse_mask;
      int slot, ph;
      logic [1:0] ch;
      logic exp_fd;
      apply_reset(4'b1010, 1'b1);
      for (int k = 1; k <= 30; k++) begin
         tick();
         slot   = (k - 1) / 5;
         ph     = (k - 1) % 5;
         ch     = (slot % 2 == 1) ? 2'd3 : 2'd1;
         exp_fd = (ph == 0) && (slot > 0) && (slot % 2 == 0);
         n_checks++;
         if ({e, a1, a0, busy} !== {(ph == 0), ch, 1'b1})
            begin n_fail++; $display("FAIL sparse k=%0d: got e,sel,busy=%b want %b", k, {e, a1, a0, busy}, {(ph == 0), ch, 1'b1}); end
         n_checks++;
         if (frame_done !== exp_fd)
            begin n_fail++; $display("FAIL sparse_fd k=%0d: got %b want %b", k, frame_done, exp_fd); end
      end
   endtask

   task automatic test_run_stop;
      apply_reset(4'hF, 1'b1);
      for (int k = 1; k <= 13; k++) tick();
      // Now in cycle 2 of the channel-2 dwell; drop run mid-dwell
      run = 1'b0;
      for (int k = 14; k <= 15; k++) begin
         tick();
         n_checks++;
         if ({e, a1, a0, busy} !== 4'b0101)
            begin n_fail++; $display("FAIL run_stop_dwell k=%0d: got %b want 0101", k, {e, a1, a0, busy}); end
      end
      for (int k = 16; k <= 20; k++) begin
         tick();
         n_checks++;
         if ({e, a1, a0, busy, frame_done} !== 5'b11000)
            begin n_fail++; $display("FAIL run_stop_idle k=%0d: got %b want 11000", k, {e, a1, a0, busy, frame_done}); end
      end
   endtask

   task automatic test_empty_then_single;
      int slot, ph;
      apply_reset(4'b0000, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_checks++;
         if ({e, a1, a0, busy} !== 4'b1000)
            begin n_fail++; $display("FAIL empty_mask k=%0d: got %b want 1000", k, {e, a1, a0, busy}); end
      end
      ch_mask = 4'b0100;
      for (int k = 1; k <= 16; k++) begin
         tick();
         slot = (k - 1) / 5;
         ph   = (k - 1) % 5;
         n_checks++;
         if ({e, a1, a0, busy, frame_done} !== {(ph == 0), 2'd2, 1'b1, (ph == 0) && (slot > 0)})
            begin n_fail++; $display("FAIL single_ch k=%0d: got %b", k, {e, a1, a0, busy, frame_done}); end
      end
   endtask

   task automatic test_reset_mid;
      apply_reset(4'hF, 1'b1);
      for (int k = 1; k <= 14; k++) tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({e, a1, a0, busy, frame_done} !== 5'b10000)
         begin n_fail++; $display("FAIL reset_mid: got %b want 10000", {e, a1, a0, busy, frame_done}); end
      // Reset landing on the frame-wrap edge must not emit a pulse
      apply_reset(4'hF, 1'b1);
      for (int k = 1; k <= 20; k++) tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({e, a1, a0, busy, frame_done} !== 5'b10000)
         begin n_fail++; $display("FAIL reset_wrap: got %b want 10000", {e, a1, a0, busy, frame_done}); end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({e, a1, a0, busy, frame_done} !== 5'b10010)
         begin n_fail++; $display("FAIL restart: got %b want 10010", {e, a1, a0, busy, frame_done}); end
   endtask

`ifdef DECODER_SCAN_HOLD_EN
   task automatic test_hold;
      int low_cnt;
      apply_reset(4'hF, 1'b1);
      for (int k = 1; k <= 11; k++) tick();
      low_cnt = 0;
      for (int k = 12; k <= 21; k++) begin
         if (k == 14) hold = 1'b1;
         if (k == 20) hold = 1'b0;
         // hold is applied just before the edge producing sample k
         tick();
         n_checks++;
         if ({e, a1, a0, busy, frame_done} !== 5'b01010)
            begin n_fail++; $display("FAIL hold k=%0d: got %b want 01010", k, {e, a1, a0, busy, frame_done}); end
         if (e == 1'b0) low_cnt++;
      end
      tick();
      n_checks++;
      if ({e, a1, a0, low_cnt} !== {3'b111, 32'd10})
         begin n_fail++; $display("FAIL hold_end: got e,sel=%b low=%0d want 111 low=10", {e, a1, a0}, low_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_full_scan();
      test_sparse_mask();
      test_run_stop();
      test_empty_then_single();
      test_reset_mid();
`ifdef DECODER_SCAN_HOLD_EN
      test_hold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
